// File: rtl/data_mem_sync.sv
// data_mem_sync: clocked single-port data RAM with post-reset clear sequencer and req/ready handshake
module data_mem_sync #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 64,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state, state_nx;
    logic [ADDR_W:0] clr_cnt;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic accept, in_range, clr_last;
    assign clr_addr  = clr_cnt[ADDR_W-1:0];
    assign busy      = state == CLEAR;
    assign req_ready = state == IDLE;
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    assign clr_last  = clr_cnt == (ADDR_W+1)'(DEPTH - 1);
    // A read coinciding with a clear write would see zero under write-first; accepts are blocked during CLEAR so this never occurs
    assign rd_word   = (WRITE_FIRST != 0 && busy && clr_addr == addr) ? '0 : mem[addr];
    // Leave CLEAR once the last word has been zeroed; only reset returns to CLEAR
    always_comb begin
        state_nx = (state == CLEAR && clr_last) ? IDLE : state;
    end
    // State, clear counter and registered read outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            rdata    <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_cnt  <= busy ? clr_cnt + 1'b1 : clr_cnt;
            rd_valid <= accept && !we;
            addr_err <= accept && !in_range;
            if (accept && !we)
                rdata <= in_range ? rd_word : '0;
        end
    end
    // Array storage: the clear sequencer owns the write port while busy
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_addr] <= '0;
        else if (accept && we && in_range)
            mem[addr] <= wdata;
    end
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: directed self-checking bench for data_mem_sync (DEPTH=64 and DEPTH=40 instances)
module tb_data_mem_sync;
    logic       clk = 1'b0;
    logic       reset;
    logic       v64, v40, we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       rdy64, rdy40, rv64, rv40, busy64, busy40, err64, err40;
    logic [7:0] rd64, rd40;
    int         errors = 0;
    int         checks = 0;

    data_mem_sync dut (
        .clk(clk), .reset(reset), .req_valid(v64), .req_ready(rdy64), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rd64), .rd_valid(rv64), .busy(busy64), .addr_err(err64)
    );
    data_mem_sync #(.DEPTH(40)) dut40 (
        .clk(clk), .reset(reset), .req_valid(v40), .req_ready(rdy40), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rd40), .rd_valid(rv40), .busy(busy40), .addr_err(err40)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit on40, input logic [5:0] a, input logic [7:0] d);
        v64 = !on40; v40 = on40; we = 1'b1; addr = a; wdata = d;
        step();
        v64 = 1'b0; v40 = 1'b0; we = 1'b0;
        chk("wr_no_rdvalid", on40 ? rv40 : rv64, 0);
    endtask

    task automatic rd(input bit on40, input logic [5:0] a, input logic [7:0] d, input logic e);
        v64 = !on40; v40 = on40; we = 1'b0; addr = a;
        step();
        v64 = 1'b0; v40 = 1'b0;
        chk($sformatf("rd_valid@%0d", a), on40 ? rv40 : rv64, 1);
        chk($sformatf("rdata@%0d", a), on40 ? rd40 : rd64, d);
        chk($sformatf("addr_err@%0d", a), on40 ? err40 : err64, e);
    endtask

    // Count busy cycles of both instances from release; optionally hammer write requests throughout
    task automatic wait_clear(input bit hammer);
        int n = 0;
        int n40 = -1;
        int bad = 0;
        while (busy64 && n < 200) begin
            if (!busy40 && n40 < 0) n40 = n;
            if (rdy64 || rv64 || err64) bad++;
            v64 = hammer; we = hammer; addr = 6'(n); wdata = 8'hFF;
            step();
            n++;
        end
        v64 = 1'b0; we = 1'b0;
        chk("busy_cycles64", n, 64);
        chk("busy_cycles40", n40, 40);
        chk("ready_low_in_clear", bad, 0);
        chk("ready_after_clear", rdy64, 1);
    endtask

    initial begin
        reset = 1'b1; v64 = 1'b0; v40 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        step(); step();
        chk("rst_busy", busy64, 1);
        chk("rst_ready", rdy64, 0);
        chk("rst_rdvalid", rv64, 0);
        chk("rst_rdata", rd64, 0);
        chk("rst_err", err64, 0);
        chk("rst_busy40", busy40, 1);
        // Release and hammer writes of 0xFF during the whole clear
        reset = 1'b0;
        wait_clear(1'b1);
        step();
        chk("no_late_write_rv", rv64, 0);
        for (int i = 0; i < 64; i++) rd(1'b0, 6'(i), 8'h00, 1'b0);
        step();
        chk("rdvalid_drops", rv64, 0);
        chk("rdata_holds", rd64, 0);
        // Write then read back, neighbour untouched
        wr(1'b0, 6'd5, 8'hA5);
        rd(1'b0, 6'd5, 8'hA5, 1'b0);
        rd(1'b0, 6'd6, 8'h00, 1'b0);
        // Back-to-back reads
        wr(1'b0, 6'd1, 8'h11);
        wr(1'b0, 6'd2, 8'h22);
        wr(1'b0, 6'd3, 8'h33);
        rd(1'b0, 6'd1, 8'h11, 1'b0);
        rd(1'b0, 6'd2, 8'h22, 1'b0);
        rd(1'b0, 6'd3, 8'h33, 1'b0);
        step();
        chk("b2b_rdvalid_end", rv64, 0);
        chk("b2b_rdata_hold", rd64, 8'h33);
        // Out-of-range handling on DEPTH=40
        wr(1'b1, 6'd45, 8'hFF);
        chk("oor_wr_err", err40, 1);
        step();
        chk("oor_err_pulse", err40, 0);
        rd(1'b1, 6'd45, 8'h00, 1'b1);
        rd(1'b1, 6'd39, 8'h00, 1'b0);
        rd(1'b1, 6'd5, 8'h00, 1'b0);
        wr(1'b1, 6'd39, 8'h77);
        chk("inrange_wr_noerr", err40, 0);
        rd(1'b1, 6'd39, 8'h77, 1'b0);
        chk("dut64_idle_untouched", rv64, 0);
        // Reset with a read in flight, then reset again mid-clear
        wr(1'b0, 6'd10, 8'h5A);
        rd(1'b0, 6'd10, 8'h5A, 1'b0);
        v64 = 1'b1; addr = 6'd10;
        step();
        v64 = 1'b0;
        chk("inflight_rv", rv64, 1);
        reset = 1'b1;
        #1;
        chk("async_rv", rv64, 0);
        chk("async_rdata", rd64, 0);
        chk("async_busy", busy64, 1);
        chk("async_ready", rdy64, 0);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("midclear_busy", busy64, 1);
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        wait_clear(1'b0);
        rd(1'b0, 6'd10, 8'h00, 1'b0);
        rd(1'b0, 6'd5, 8'h00, 1'b0);
        rd(1'b1, 6'd39, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
